// File: rtl/spi_arbiter.sv
// Round-robin arbiter that shares one single-byte SPI master among NREQ requesters.
// Each grant sequences the master's ready_send/ss handshake under a per-phase watchdog.
module spi_arbiter #(
  parameter int NREQ      = 4,
  parameter int TO_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic [7:0]        spi_data_in,
  output logic              spi_ready_send,
  input  logic              spi_ss,
  input  logic [7:0]        spi_data_out
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TO_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] ptr_next;
  logic [PW:0]   scan;
  logic          found;
  logic [NREQ-1:0] win_onehot;
  logic [CW-1:0] wd_cnt;
  logic          wd_expired;

  // First set request scanning upward from the pointer, wrapping at NREQ.
  always_comb begin
    win        = '0;
    scan       = '0;
    found      = 1'b0;
    win_onehot = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, ptr} + (PW+1)'(k);
      if (scan >= (PW+1)'(NREQ)) scan = scan - (PW+1)'(NREQ);
      if (!found && req[scan[PW-1:0]]) begin
        found = 1'b1;
        win   = scan[PW-1:0];
      end
    end
    win_onehot[win] = 1'b1;
  end

  assign ptr_next   = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
  assign wd_expired = (wd_cnt == CW'(TO_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      ptr            <= '0;
      wd_cnt         <= '0;
      gnt            <= '0;
      done           <= '0;
      err            <= 1'b0;
      rdata          <= 8'h00;
      busy           <= 1'b0;
      spi_data_in    <= 8'h00;
      spi_ready_send <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            state          <= S_START;
            gnt            <= win_onehot;
            spi_data_in    <= req_data[{win, 3'b000} +: 8];
            ptr            <= ptr_next;
            busy           <= 1'b1;
            spi_ready_send <= 1'b1;
            wd_cnt         <= '0;
          end
        end
        S_START: begin
          if (spi_ss) begin
            state          <= S_XFER;
            spi_ready_send <= 1'b0;
            wd_cnt         <= '0;
          end else if (wd_expired) begin
            state          <= S_DONE;
            spi_ready_send <= 1'b0;
            done           <= gnt;
            err            <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_XFER: begin
          // An abort leaves rdata holding the last good byte.
          if (!spi_ss) begin
            state <= S_DONE;
            rdata <= spi_data_out;
            done  <= gnt;
            err   <= 1'b0;
          end else if (wd_expired) begin
            state <= S_DONE;
            done  <= gnt;
            err   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          gnt   <= '0;
          done  <= '0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: a behavioural SPI master answers each byte with byte^0x24,
// expected completions are queued as requests are issued and popped on every done pulse.
module tb_spi_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              err;
  logic [7:0]        rdata;
  logic              busy;
  logic [7:0]        spi_data_in;
  logic              spi_ready_send;
  logic              spi_ss;
  logic [7:0]        spi_data_out;

  spi_arbiter #(.NREQ(NREQ), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
    .spi_data_in(spi_data_in), .spi_ready_send(spi_ready_send),
    .spi_ss(spi_ss), .spi_data_out(spi_data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] done;
    logic [7:0]      rdata;
    logic            err;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  int         pend[NREQ];
  int         master_mode = 0;
  logic [7:0] last_rdata = 8'h00;
  int         last_lat = 0;
  logic       rs_at_done = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic pushExp(input int idx, input logic [7:0] data, input logic is_err);
    exp_t e;
    e.done      = '0;
    e.done[idx] = 1'b1;
    if (!is_err) last_rdata = data ^ 8'h24;
    e.rdata = last_rdata;
    e.err   = is_err;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] data, input int count);
    req_data[idx*8 +: 8] = data;
    pend[idx] += count;
    req[idx] = 1'b1;
  endtask

  task automatic checkReset(input string pfx);
    checkOutput({pfx, "_gnt"},   32'(gnt), 32'h0);
    checkOutput({pfx, "_done"},  32'(done), 32'h0);
    checkOutput({pfx, "_err"},   32'(err), 32'h0);
    checkOutput({pfx, "_rdata"}, 32'(rdata), 32'h0);
    checkOutput({pfx, "_busy"},  32'(busy), 32'h0);
    checkOutput({pfx, "_din"},   32'(spi_data_in), 32'h0);
    checkOutput({pfx, "_rdy"},   32'(spi_ready_send), 32'h0);
  endtask

  // Plays the requesters: drops req after the last wanted done, checks the IDLE gap.
  task automatic drain(input int budget);
    int since = -1;
    int rise = 0;
    logic ok = 1'b0;
    logic [NREQ-1:0] pg = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (gnt != '0 && pg == '0) rise = c;
      pg = gnt;
      if (since >= 0) since++;
      if (since == 1) begin
        checkOutput("idle_gap_gnt", 32'(gnt), 32'h0);
        checkOutput("done_one_cycle", 32'(done), 32'h0);
      end
      if (since == 2 && req != '0) checkOutput("regrant", 32'(gnt != '0), 32'h1);
      if (done != '0) begin
        since      = 0;
        last_lat   = c - rise;
        rs_at_done = spi_ready_send;
        for (int i = 0; i < NREQ; i++) begin
          if (done[i]) begin
            pend[i]--;
            if (pend[i] <= 0) req[i] = 1'b0;
          end
        end
      end
      if (req == '0 && !busy && done == '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("drain_timeout", 32'h0, 32'h1);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done != '0) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 32'(done), 32'h0);
        end else begin
          e = sb.pop_front();
          checkOutput("done", 32'(done), 32'(e.done));
          checkOutput("gnt_at_done", 32'(gnt), 32'(e.done));
          checkOutput("rdata", 32'(rdata), 32'(e.rdata));
          checkOutput("err", 32'(err), 32'(e.err));
        end
      end
    end
  end

  // SPI master model: mode 0 normal, 1 ss never rises, 2 ss rises and sticks.
  initial begin
    logic [7:0] snap;
    spi_ss       = 1'b0;
    spi_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (master_mode == 0 && spi_ss) begin
        spi_ss = 1'b0;
      end else if (master_mode == 0 && spi_ready_send) begin
        snap = spi_data_in;
        repeat (2) @(negedge clk);
        spi_ss = 1'b1;
        repeat (3) @(negedge clk);
        spi_data_out = snap ^ 8'h24;
        spi_ss = 1'b0;
      end else if (master_mode == 2 && spi_ready_send) begin
        spi_ss = 1'b1;
      end
    end
  end

  initial begin
    logic seen;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    repeat (3) @(negedge clk);
    checkReset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Contention: all four request, requester 0 wants two bytes.
    pushExp(0, 8'hA0, 1'b0);
    pushExp(1, 8'hA1, 1'b0);
    pushExp(2, 8'hA2, 1'b0);
    pushExp(3, 8'hA3, 1'b0);
    pushExp(0, 8'hA0, 1'b0);
    applyStimulus(0, 8'hA0, 2);
    applyStimulus(1, 8'hA1, 1);
    applyStimulus(2, 8'hA2, 1);
    applyStimulus(3, 8'hA3, 1);
    drain(300);

    // Single transfer 0x13 -> 0x37.
    pushExp(0, 8'h13, 1'b0);
    applyStimulus(0, 8'h13, 1);
    drain(100);
    checkOutput("single_latency", 32'(last_lat), 32'd6);
    checkOutput("single_rdata", 32'(rdata), 32'h37);

    // Pointer wrap: grant 2, then 0101 grants 0 before 2.
    pushExp(2, 8'h55, 1'b0);
    applyStimulus(2, 8'h55, 1);
    drain(100);
    pushExp(0, 8'h61, 1'b0);
    pushExp(2, 8'h62, 1'b0);
    applyStimulus(0, 8'h61, 1);
    applyStimulus(2, 8'h62, 1);
    drain(200);

    // Start timeout.
    master_mode = 1;
    pushExp(1, 8'h77, 1'b1);
    applyStimulus(1, 8'h77, 1);
    drain(100);
    checkOutput("start_to_latency", 32'(last_lat), 32'd17);
    checkOutput("start_to_rdy", 32'(rs_at_done), 32'h0);
    master_mode = 0;

    // Stuck transfer, then a normal one.
    master_mode = 2;
    pushExp(3, 8'h88, 1'b1);
    applyStimulus(3, 8'h88, 1);
    drain(100);
    checkOutput("xfer_to_latency", 32'(last_lat), 32'd18);
    checkOutput("xfer_to_rdy", 32'(rs_at_done), 32'h0);
    master_mode = 0;
    repeat (3) @(negedge clk);
    pushExp(2, 8'h99, 1'b0);
    applyStimulus(2, 8'h99, 1);
    drain(100);

    // Reset mid-XFER: no done, pointer back to 0.
    applyStimulus(1, 8'h44, 1);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (spi_ss) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("reach_xfer", 32'(seen), 32'h1);
    @(negedge clk);
    rst     = 1'b1;
    req     = '0;
    pend[1] = 0;
    @(negedge clk);
    checkReset("midreset");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    pushExp(0, 8'hC0, 1'b0);
    pushExp(3, 8'hC3, 1'b0);
    applyStimulus(3, 8'hC3, 1);
    applyStimulus(0, 8'hC0, 1);
    drain(200);

    checkOutput("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin arbiter and transaction sequencer that shares the single-byte `spi` master among `NREQ` on-chip requesters. It accepts one-byte transfer requests, drives the master's `data_in`/`ready_send` handshake and tracks `ss` to detect the start and end of each transfer. It returns the received byte to the granted requester with a completion pulse. A watchdog aborts transfers whose `ss` handshake never starts or never ends.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `TO_CYCLES`, 1024: watchdog limit in `clk` cycles, applied separately to each phase (START and XFER).

Ports:
- `clk` in 1: single system clock, shared with the `spi` master.
- `rst` in 1: synchronous, active-high reset.
- `req` in NREQ: requester i asks for a transfer; held high until `done[i]`.
- `req_data` in 8*NREQ: byte for requester i in bits [8i+7:8i].
- `gnt` out NREQ: one-hot; held from acceptance through the DONE cycle.
- `done` out NREQ: one-cycle completion pulse to the granted requester.
- `err` out 1: one-cycle pulse coincident with `done`; set when the watchdog aborts the transfer.
- `rdata` out 8: received byte; valid while `done` is high, held until the next DONE.
- `busy` out 1: high in any state other than IDLE.
- `spi_data_in` out 8: to master `data_in`.
- `spi_ready_send` out 1: to master `ready_send`.
- `spi_ss` in 1: from master `ss`; high while a transfer is in progress.
- `spi_data_out` in 8: from master `data_out`; valid once `ss` has fallen.

## Operation
- All outputs are registered. Reset values: `gnt`=0, `done`=0, `err`=0, `rdata`=0x00, `busy`=0, `spi_data_in`=0x00, `spi_ready_send`=0. The state goes to IDLE and the priority pointer to 0.
- States:
  - IDLE: arbitrates among `req`.
  - START: `spi_ready_send`=1; waits for `spi_ss`=1.
  - XFER: `spi_ready_send`=0; waits for `spi_ss`=0.
  - DONE: one cycle.
- IDLE -> START when any `req` bit is high. The winner is the first set bit scanning upward from the pointer, modulo `NREQ`. On entry: `gnt` is set to the winner, `spi_data_in` loads its `req_data` slice, and the pointer becomes winner+1 mod `NREQ`.
- START -> XFER on the first cycle `spi_ss`=1 is sampled.
- XFER -> DONE on the first cycle `spi_ss`=0 is sampled. On entry `rdata` captures `spi_data_out`, `done[winner]`=1 and `err`=0.
- DONE -> IDLE unconditionally. `gnt` and `done` clear on leaving DONE.
- Watchdog: a counter clears on entry to START and again on entry to XFER. If it reaches `TO_CYCLES` with no exit condition, the arbiter goes to DONE with `err`=1 and `spi_ready_send`=0. `rdata` is not updated on an abort.
- `spi_data_in` holds stable from START entry until the next grant.
- Dropping `req[i]` while granted has no effect. The transfer completes and `done[i]` still pulses.
- A `req` bit still high in the IDLE cycle after DONE counts as a new request. Requesters drop `req` during their `done` cycle if no further transfer is wanted.
- `req` changes during START, XFER or DONE are ignored until IDLE.
- `rst` in any state aborts immediately. No `done` is issued and the master is reset by the same `rst`.

## Timing
- `req` sampled high in IDLE at cycle N -> `gnt`, `busy` and `spi_ready_send` high at N+1.
- `spi_ss` rise sampled at cycle M -> `spi_ready_send` low at M+1.
- `spi_ss` fall sampled at cycle K -> `done`, `rdata` and `err` valid at K+1, `gnt` low at K+2.
- Back-to-back transfers: `gnt` is low for exactly one cycle (the IDLE cycle) between transfers.
- Timeout abort: `done`/`err` appear `TO_CYCLES`+1 cycles after phase entry.

## Test plan
- Single transfer: `req`=0001, `req_data[7:0]`=0x13; slave model drives 0x37 on `miso` -> `spi_data_in`=0x13 through the transfer, `done`=0001 for one cycle, `rdata`=0x37, `err`=0.
- Contention: `req`=1111 held for four transfers -> grant order 0,1,2,3, then 0 again; each `done` one-hot, one IDLE cycle between grants.
- Pointer wrap: after a grant to 2, present `req`=0101 -> grant goes to 0, next grant to 2.
- Start timeout: `TO_CYCLES`=16, `spi_ss` forced 0, `req`=0010 -> `done`=0010 with `err`=1 exactly 17 cycles after `gnt` rises, `spi_ready_send` low, `rdata` unchanged.
- Stuck transfer: `spi_ss` forced 1 after start -> `err` pulse 17 cycles after XFER entry; the next request is arbitrated normally.
- Reset mid-XFER: assert `rst` for one cycle during transfer -> next cycle all outputs are at reset values, no `done` pulse, and the pointer restarts at 0 (`req`=1000 then 0001 together grants 0 first).
